// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline register,
// sticky misaligned-redirect flag and saturating fetch/stall/flush counters.
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_write,
    input  logic             ifid_write,
    input  logic             if_flush,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc_out_IF,
    output logic [31:0]      pc_plus_4,
    output logic [31:0]      pc_in_IF,
    output logic [31:0]      instruction_IF,
    output logic [31:0]      instruction_ID,
    output logic [31:0]      pc_plus_4_ID,
    output logic             valid_ID,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_id_q, instr_id_d;
    logic [31:0]      p4_id_q, p4_id_d;
    logic             valid_id_q, valid_id_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             redirect;
    logic [31:0]      redirect_tgt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + CNT_W'(1);
    endfunction

    // Next-PC mux: jump beats branch beats sequential; targets are forced word-aligned.
    always_comb begin
        redirect     = 1'b0;
        redirect_tgt = 32'h0;
        if (jump) begin
            redirect     = 1'b1;
            redirect_tgt = jump_target;
        end else if (branch_taken) begin
            redirect     = 1'b1;
            redirect_tgt = branch_target;
        end
        pc_plus_4 = pc_q + 32'd4;
        pc_in_IF  = redirect ? {redirect_tgt[31:2], 2'b00} : pc_plus_4;
    end

    // Next-state for PC, IF/ID register, error flag and counters.
    always_comb begin
        pc_d        = pc_q;
        instr_id_d  = instr_id_q;
        p4_id_d     = p4_id_q;
        valid_id_d  = valid_id_q;
        misalign_d  = misalign_q;
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        // A redirect seen while the PC is held is dropped; the hazard unit re-issues it.
        if (pc_write) begin
            pc_d        = pc_in_IF;
            fetch_cnt_d = sat_inc(fetch_cnt_q);
            if (redirect && (redirect_tgt[1:0] != 2'b00)) begin
                misalign_d = 1'b1;
            end
        end else begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end

        // Flush inserts sll $0,$0,0 and wins over a held IF/ID register.
        if (if_flush) begin
            instr_id_d  = 32'h0;
            p4_id_d     = 32'h0;
            valid_id_d  = 1'b0;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (ifid_write) begin
            instr_id_d = imem_rdata;
            p4_id_d    = pc_plus_4;
            valid_id_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= PC_RESET;
            instr_id_q  <= 32'h0;
            p4_id_q     <= 32'h0;
            valid_id_q  <= 1'b0;
            misalign_q  <= 1'b0;
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_id_q  <= instr_id_d;
            p4_id_q     <= p4_id_d;
            valid_id_q  <= valid_id_d;
            misalign_q  <= misalign_d;
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign imem_addr      = pc_q;
    assign pc_out_IF      = pc_q;
    assign instruction_IF = imem_rdata;
    assign instruction_ID = instr_id_q;
    assign pc_plus_4_ID   = p4_id_q;
    assign valid_ID       = valid_id_q;
    assign misalign_err   = misalign_q;
    assign fetch_count    = fetch_cnt_q;
    assign stall_count    = stall_cnt_q;
    assign flush_count    = flush_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a vector table driven through a scoreboard queue, then hand-written
// sequences for counter saturation, PC wrap and reset. A second instance with 4-bit
// counters and a non-zero reset PC shares the stimulus.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n, pc_write, ifid_write, if_flush, branch_taken, jump;
    logic [31:0] branch_target, jump_target;

    logic [31:0] imem_rdata, imem_addr, pc_out_IF, pc_plus_4, pc_in_IF, instruction_IF;
    logic [31:0] instruction_ID, pc_plus_4_ID;
    logic        valid_ID, misalign_err;
    logic [15:0] fetch_count, stall_count, flush_count;

    logic [31:0] s_imem_rdata, s_imem_addr, s_pc_out_IF, s_pc_plus_4, s_pc_in_IF;
    logic [31:0] s_instruction_IF, s_instruction_ID, s_pc_plus_4_ID;
    logic        s_valid_ID, s_misalign_err;
    logic [3:0]  s_fetch_count, s_stall_count, s_flush_count;

    // Instruction memory model: word depends on the address so holds are observable.
    assign imem_rdata   = 32'h2008_0005 + (imem_addr << 16);
    assign s_imem_rdata = 32'h2008_0005 + (s_imem_addr << 16);

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .ifid_write(ifid_write),
        .if_flush(if_flush), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .imem_rdata(imem_rdata),
        .imem_addr(imem_addr), .pc_out_IF(pc_out_IF), .pc_plus_4(pc_plus_4),
        .pc_in_IF(pc_in_IF), .instruction_IF(instruction_IF),
        .instruction_ID(instruction_ID), .pc_plus_4_ID(pc_plus_4_ID), .valid_ID(valid_ID),
        .misalign_err(misalign_err), .fetch_count(fetch_count), .stall_count(stall_count),
        .flush_count(flush_count)
    );

    if_stage #(.PC_RESET(32'h0000_1000), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .ifid_write(ifid_write),
        .if_flush(if_flush), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .imem_rdata(s_imem_rdata),
        .imem_addr(s_imem_addr), .pc_out_IF(s_pc_out_IF), .pc_plus_4(s_pc_plus_4),
        .pc_in_IF(s_pc_in_IF), .instruction_IF(s_instruction_IF),
        .instruction_ID(s_instruction_ID), .pc_plus_4_ID(s_pc_plus_4_ID),
        .valid_ID(s_valid_ID), .misalign_err(s_misalign_err),
        .fetch_count(s_fetch_count), .stall_count(s_stall_count),
        .flush_count(s_flush_count)
    );

    typedef struct {
        logic        rst_n, pw, iw, fl, br;
        logic [31:0] bt;
        logic        jm;
        logic [31:0] jt;
        logic        chk_comb;
        logic [31:0] e_pc_in, e_pc, e_id, e_p4;
        logic        e_valid, e_mis;
        logic [15:0] e_fetch, e_stall, e_flush;
    } vec_t;

    typedef struct {
        logic [31:0] pc, id, p4;
        logic        valid, mis;
        logic [15:0] fetch, stall, flush;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic pw, input logic iw, input logic fl,
                         input logic br, input logic [31:0] bt, input logic jm,
                         input logic [31:0] jt);
        rst_n = r; pc_write = pw; ifid_write = iw; if_flush = fl;
        branch_taken = br; branch_target = bt; jump = jm; jump_target = jt;
    endtask

    function automatic logic [3:0] sat4(input int v);
        return (v > 15) ? 4'hF : v[3:0];
    endfunction

    logic [31:0] prev_pc;
    exp_t        e;
    int          big_stall;

    initial begin
        //                rst pw iw fl br bt       jm jt         chk pc_in
        //                pc        id              p4       v  mis fetch stall flush
        vecs.push_back('{0,0,0,0,0,32'h0,  0,32'h0,   0,32'h0,
                         32'h0,    32'h0,          32'h0,   0,0,  0,0,0});
        vecs.push_back('{1,1,1,0,0,32'h0,  0,32'h0,   1,32'h4,
                         32'h4,    32'h2008_0005,  32'h4,   1,0,  1,0,0});
        vecs.push_back('{1,1,1,0,0,32'h0,  0,32'h0,   1,32'h8,
                         32'h8,    32'h200C_0005,  32'h8,   1,0,  2,0,0});
        vecs.push_back('{1,0,0,0,0,32'h0,  0,32'h0,   1,32'hC,
                         32'h8,    32'h200C_0005,  32'h8,   1,0,  2,1,0});
        vecs.push_back('{1,0,0,0,0,32'h0,  0,32'h0,   1,32'hC,
                         32'h8,    32'h200C_0005,  32'h8,   1,0,  2,2,0});
        vecs.push_back('{1,1,1,0,0,32'h0,  0,32'h0,   1,32'hC,
                         32'hC,    32'h2010_0005,  32'hC,   1,0,  3,2,0});
        vecs.push_back('{1,1,1,0,0,32'h0,  0,32'h0,   1,32'h10,
                         32'h10,   32'h2014_0005,  32'h10,  1,0,  4,2,0});
        vecs.push_back('{1,1,1,1,1,32'h40, 0,32'h0,   1,32'h40,
                         32'h40,   32'h0,          32'h0,   0,0,  5,2,1});
        vecs.push_back('{1,1,1,0,1,32'h80, 1,32'h102, 1,32'h100,
                         32'h100,  32'h2048_0005,  32'h44,  1,1,  6,2,1});
        vecs.push_back('{1,1,1,0,0,32'h0,  0,32'h0,   1,32'h104,
                         32'h104,  32'h2108_0005,  32'h104, 1,1,  7,2,1});
        vecs.push_back('{1,0,1,0,1,32'h200,0,32'h0,   1,32'h200,
                         32'h104,  32'h210C_0005,  32'h108, 1,1,  7,3,1});
        vecs.push_back('{1,1,1,0,0,32'h0,  0,32'h0,   1,32'h108,
                         32'h108,  32'h210C_0005,  32'h108, 1,1,  8,3,1});
        vecs.push_back('{1,1,0,1,0,32'h0,  0,32'h0,   1,32'h10C,
                         32'h10C,  32'h0,          32'h0,   0,1,  9,3,2});
        vecs.push_back('{0,1,1,0,0,32'h0,  1,32'h500, 1,32'h500,
                         32'h0,    32'h0,          32'h0,   0,0,  0,0,0});
        vecs.push_back('{1,0,0,0,1,32'h41, 0,32'h0,   1,32'h40,
                         32'h0,    32'h0,          32'h0,   0,0,  0,1,0});
        vecs.push_back('{1,1,1,0,0,32'h0,  0,32'h0,   1,32'h4,
                         32'h4,    32'h2008_0005,  32'h4,   1,0,  1,1,0});

        prev_pc = 32'h0;
        drive(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        #2;
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].br, vecs[i].bt,
                  vecs[i].jm, vecs[i].jt);
            sb.push_back('{vecs[i].e_pc, vecs[i].e_id, vecs[i].e_p4, vecs[i].e_valid,
                           vecs[i].e_mis, vecs[i].e_fetch, vecs[i].e_stall, vecs[i].e_flush});
            #1;
            if (vecs[i].chk_comb) begin
                check($sformatf("v%0d pc_in_IF", i), pc_in_IF, vecs[i].e_pc_in);
                check($sformatf("v%0d pc_plus_4", i), pc_plus_4, prev_pc + 32'd4);
                check($sformatf("v%0d imem_addr", i), imem_addr, prev_pc);
                check($sformatf("v%0d instruction_IF", i), instruction_IF,
                      32'h2008_0005 + (prev_pc << 16));
            end
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("v%0d pc_out_IF", i), pc_out_IF, e.pc);
            check($sformatf("v%0d instruction_ID", i), instruction_ID, e.id);
            check($sformatf("v%0d pc_plus_4_ID", i), pc_plus_4_ID, e.p4);
            check($sformatf("v%0d valid_ID", i), {31'h0, valid_ID}, {31'h0, e.valid});
            check($sformatf("v%0d misalign_err", i), {31'h0, misalign_err}, {31'h0, e.mis});
            check($sformatf("v%0d fetch_count", i), {16'h0, fetch_count}, {16'h0, e.fetch});
            check($sformatf("v%0d stall_count", i), {16'h0, stall_count}, {16'h0, e.stall});
            check($sformatf("v%0d flush_count", i), {16'h0, flush_count}, {16'h0, e.flush});
            check($sformatf("v%0d small fetch", i), {28'h0, s_fetch_count},
                  {28'h0, sat4(int'(e.fetch))});
            check($sformatf("v%0d small stall", i), {28'h0, s_stall_count},
                  {28'h0, sat4(int'(e.stall))});
            prev_pc = e.pc;
        end

        // 20 stall cycles: the 4-bit counter must stick at 15.
        big_stall = 1;
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
            @(posedge clk);
            #1;
            big_stall++;
            check($sformatf("sat%0d small stall", i), {28'h0, s_stall_count},
                  {28'h0, sat4(big_stall)});
        end
        check("sat big stall", {16'h0, stall_count}, 32'd21);
        check("sat pc held", pc_out_IF, 32'h4);
        check("sat small fetch", {28'h0, s_fetch_count}, 32'd1);

        // PC wraps from 0xFFFF_FFFC to 0.
        drive(1, 1, 1, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        drive(1, 1, 1, 0, 0, 32'h0, 0, 32'h0);
        #1;
        check("wrap pc", pc_out_IF, 32'hFFFF_FFFC);
        check("wrap pc_plus_4", pc_plus_4, 32'h0);
        check("wrap pc_in_IF", pc_in_IF, 32'h0);
        @(posedge clk);
        #1;
        check("wrap next pc", pc_out_IF, 32'h0);
        check("wrap p4_ID", pc_plus_4_ID, 32'h0);
        check("wrap misalign", {31'h0, misalign_err}, 32'h0);

        // One reset edge during a stall with a redirect pending.
        drive(0, 0, 1, 0, 1, 32'h300, 0, 32'h0);
        @(posedge clk);
        #1;
        check("rst pc", pc_out_IF, 32'h0);
        check("rst small pc", s_pc_out_IF, 32'h0000_1000);
        check("rst fetch", {16'h0, fetch_count}, 32'h0);
        check("rst stall", {16'h0, stall_count}, 32'h0);
        check("rst flush", {16'h0, flush_count}, 32'h0);
        check("rst small stall", {28'h0, s_stall_count}, 32'h0);
        check("rst valid", {31'h0, valid_ID}, 32'h0);
        check("rst instr_ID", instruction_ID, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS CPU (pipcpu).
- Holds the PC register and computes PC+4 and the next PC (sequential, branch, or jump redirect).
- Drives the instruction-memory address and captures the fetched word into the IF/ID pipeline register, with stall (hold) and IFflush (bubble) control.
- Carries saturating fetch/stall/flush performance counters for simulation and debug.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- pc_write  in  1  1 = PC may update; 0 = hold PC (load-use stall).
- ifid_write  in  1  1 = IF/ID register may load; 0 = hold.
- if_flush  in  1  IFflush: replace IF/ID contents with a bubble.
- branch_taken  in  1  branch resolved taken in ID.
- branch_target  in  32  branch destination.
- jump  in  1  j/jal in ID.
- jump_target  in  32  jump destination.
- imem_rdata  in  32  instruction word at imem_addr (combinational read).
- imem_addr  out  32  equals pc_out_IF.
- pc_out_IF  out  32  current PC.
- pc_plus_4  out  32  pc_out_IF + 4.
- pc_in_IF  out  32  next-PC mux output.
- instruction_IF  out  32  equals imem_rdata.
- instruction_ID  out  32  IF/ID instruction.
- pc_plus_4_ID  out  32  IF/ID PC+4.
- valid_ID  out  1  IF/ID holds a real instruction.
- misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0.
- fetch_count  out  CNT_W  cycles in which the PC advanced.
- stall_count  out  CNT_W  cycles with pc_write = 0.
- flush_count  out  CNT_W  cycles with if_flush = 1.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous, active-low, on rst_n: sampled on posedge clk and overrides all other inputs.
- Reset values:
  - pc_out_IF = PC_RESET.
  - instruction_ID = 0, pc_plus_4_ID = 0, valid_ID = 0.
  - misalign_err = 0; all counters = 0.
- Combinational paths:
  - pc_plus_4 = pc_out_IF + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - imem_addr = pc_out_IF; instruction_IF = imem_rdata.
- Next-PC mux, priority:
  - jump → {jump_target[31:2], 2'b00}.
  - Else branch_taken → {branch_target[31:2], 2'b00}.
  - Else pc_plus_4.
- PC update on posedge:
  - If pc_write = 1, PC ← pc_in_IF.
  - If pc_write = 0, PC holds and any redirect that cycle is dropped. The hazard unit must re-assert the redirect after the stall.
- misalign_err:
  - Set on a posedge where pc_write = 1 and the selected redirect target has nonzero bits [1:0].
  - Cleared only by reset.
- IF/ID register, priority:
  - if_flush = 1 → instruction_ID ← 0 (sll $0,$0,0 NOP), pc_plus_4_ID ← 0, valid_ID ← 0. Flush wins even when ifid_write = 0.
  - Else ifid_write = 1 → instruction_ID ← imem_rdata, pc_plus_4_ID ← pc_plus_4, valid_ID ← 1.
  - Else hold.
- Latency:
  - Fetched word appears in instruction_ID one cycle after the PC presents it.
  - A redirect asserted in cycle N makes pc_out_IF = target in cycle N+1.
- Counters:
  - fetch_count increments when pc_write = 1.
  - stall_count increments when pc_write = 0.
  - flush_count increments when if_flush = 1.
  - Each saturates at 2^CNT_W − 1 and never wraps.
  - Counters do not increment in a reset cycle.
- Reset mid-operation: an asserted rst_n during a stall or redirect restores every reset value on that edge; that cycle's redirect is discarded.

Test Plan:
- Reset then 4 free-running cycles with pc_write = ifid_write = 1 and imem returning 0x2008_0005 → pc_out_IF 0, 4, 8, 12; instruction_ID = 0x2008_0005 and valid_ID = 1 from cycle 2; fetch_count = 4.
- At PC = 8, pc_write = ifid_write = 0 for 2 cycles → pc_out_IF stays 8 and instruction_ID holds; stall_count = 2; then resumes at 12.
- At PC = 16, branch_taken = 1, branch_target = 0x40, if_flush = 1 → next pc_out_IF = 0x40; instruction_ID = 0, valid_ID = 0; flush_count = 1.
- jump = 1 and branch_taken = 1 together, jump_target = 0x0000_0102, branch_target = 0x80 → pc_out_IF = 0x100; misalign_err = 1 and stays 1.
- branch_taken = 1 with pc_write = 0 → PC unchanged; a following idle cycle gives PC+4, not the target.
- CNT_W = 4 with 20 stall cycles → stall_count = 15; then rst_n = 0 for one edge → all counters 0, pc_out_IF = PC_RESET.
